// File: rtl/prog_counter_pkg.sv
// Shared types for the programmable counter: mode encoding and direction constants.
package prog_counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP       = 2'b00,
        MODE_DOWN     = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/prog_counter_prescaler.sv
// Prescaler for the programmable counter: emits one tick every prescale+1 enabled cycles.
module prog_counter_prescaler #(
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt_q;
    logic [PRE_W-1:0] pre_cnt_d;

    // A prescale value written below pre_cnt lets the count run through the top and wrap before ticking.
    assign tick = en && !clr && (pre_cnt_q == prescale);

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (clr) begin
            pre_cnt_d = '0;
        end else if (en) begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Programmable counter: up/down/ping-pong/hold modes with modulo limit, load, compare match and wrap pulse.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [PRE_W-1:0] prescale,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             wrap,
    output logic             match
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             tick;
    mode_e            mode_sel;
    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic             match_q, match_d;

    assign mode_sel = mode_e'(mode);

    prog_counter_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (load),
        .prescale (prescale),
        .tick     (tick)
    );

    // Next count/direction; dir doubles as the ping-pong UP/DOWN state and only moves on ticks.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = (load_val > limit) ? limit : load_val;
        end else if (tick) begin
            case (mode_sel)
                MODE_UP: begin
                    dir_d = DIR_UP;
                    if (count_q >= limit) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
                MODE_DOWN: begin
                    dir_d = DIR_DOWN;
                    if (count_q == '0 || count_q > limit) begin
                        count_d = limit;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q - ONE;
                    end
                end
                MODE_PINGPONG: begin
                    if (dir_q == DIR_UP) begin
                        if (count_q >= limit) begin
                            dir_d   = DIR_DOWN;
                            count_d = (limit == '0) ? '0 : limit - ONE;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q + ONE;
                        end
                    end else begin
                        if (count_q == '0) begin
                            dir_d   = DIR_UP;
                            count_d = (limit == '0) ? '0 : ONE;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q - ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
        match_d = (count_d == cmp_val);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            dir_q   <= DIR_UP;
            wrap_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            match_q <= match_d;
        end
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign wrap  = wrap_q;
    assign match = match_q;

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter: a behavioural model queues expected outputs, a monitor checks them.
module tb_prog_counter;

    localparam int WIDTH = 8;
    localparam int PRE_W = 4;

    typedef struct {
        int count;
        int dir;
        int wrap;
        int match;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [1:0]       mode;
    logic [PRE_W-1:0] prescale;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] cmp_val;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             wrap;
    logic             match;

    exp_t exp_q[$];
    int   tests = 0;
    int   failures = 0;

    int m_count = 0;
    int m_pre   = 0;
    int m_dir   = 0;
    int m_wrap  = 0;
    int m_match = 0;

    prog_counter #(
        .WIDTH (WIDTH),
        .PRE_W (PRE_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .prescale (prescale),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .cmp_val  (cmp_val),
        .count    (count),
        .dir      (dir),
        .wrap     (wrap),
        .match    (match)
    );

    always #5 clk = ~clk;

    // Reference model: what the counter must show after the coming clock edge, from the behavioural rules.
    task automatic modelStep();
        exp_t e;
        int   lim;
        bit   tick;
        lim  = int'(limit);
        tick = 1'b0;
        if (!rst_n) begin
            m_count = 0;
            m_pre   = 0;
            m_dir   = 0;
            m_wrap  = 0;
            m_match = 0;
        end else begin
            m_wrap = 0;
            if (load) begin
                m_count = (int'(load_val) > lim) ? lim : int'(load_val);
                m_pre   = 0;
            end else if (en) begin
                if (m_pre == int'(prescale)) begin
                    tick  = 1'b1;
                    m_pre = 0;
                end else begin
                    m_pre = (m_pre + 1) % (1 << PRE_W);
                end
            end
            if (tick) begin
                if (mode == 2'd0) begin
                    m_dir = 0;
                    if (m_count >= lim) begin m_count = 0; m_wrap = 1; end
                    else m_count = m_count + 1;
                end else if (mode == 2'd1) begin
                    m_dir = 1;
                    if (m_count == 0 || m_count > lim) begin m_count = lim; m_wrap = 1; end
                    else m_count = m_count - 1;
                end else if (mode == 2'd2) begin
                    if (m_dir == 0 && m_count >= lim) begin
                        m_dir = 1; m_count = (lim == 0) ? 0 : lim - 1; m_wrap = 1;
                    end else if (m_dir == 0) begin
                        m_count = m_count + 1;
                    end else if (m_count == 0) begin
                        m_dir = 0; m_count = (lim == 0) ? 0 : 1; m_wrap = 1;
                    end else begin
                        m_count = m_count - 1;
                    end
                end
            end
            m_match = (m_count == int'(cmp_val)) ? 1 : 0;
        end
        e.count = m_count;
        e.dir   = m_dir;
        e.wrap  = m_wrap;
        e.match = m_match;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            modelStep();
            @(negedge clk);
        end
    endtask

    task automatic compareField(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField("count", int'(count), e.count);
        compareField("dir",   int'(dir),   e.dir);
        compareField("wrap",  int'(wrap),  e.wrap);
        compareField("match", int'(match), e.match);
    endtask

    // Monitor: outputs are valid every cycle, so one expectation is consumed shortly after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        int drain;
        rst_n    = 1'b0;
        en       = 1'b0;
        mode     = 2'd0;
        prescale = '0;
        load     = 1'b1;
        load_val = 8'd77;
        limit    = 8'd255;
        cmp_val  = 8'd0;
        applyStimulus(3);

        rst_n = 1'b1; load = 1'b0; en = 1'b1;
        applyStimulus(300);

        load = 1'b1; load_val = 8'd0; limit = 8'd5; prescale = 4'd2; cmp_val = 8'd200;
        applyStimulus(1);
        load = 1'b0;
        applyStimulus(40);
        en = 1'b0;
        applyStimulus(4);
        en = 1'b1;
        applyStimulus(30);

        load = 1'b1; load_val = 8'd0; mode = 2'd2; limit = 8'd3; prescale = 4'd0;
        applyStimulus(1);
        load = 1'b0;
        applyStimulus(20);

        mode = 2'd1; load = 1'b1; load_val = 8'd200; limit = 8'd100;
        applyStimulus(1);
        load = 1'b0;
        applyStimulus(110);

        mode = 2'd0; limit = 8'd9; cmp_val = 8'd7; load = 1'b1; load_val = 8'd0;
        applyStimulus(1);
        load = 1'b0;
        applyStimulus(30);
        load = 1'b1; load_val = 8'd7;
        applyStimulus(1);
        load = 1'b0;
        applyStimulus(5);

        mode = 2'd1; limit = 8'd255; prescale = 4'd3;
        applyStimulus(6);
        load = 1'b1; load_val = 8'd42;
        applyStimulus(1);
        rst_n = 1'b0; load_val = 8'd99;
        applyStimulus(1);
        rst_n = 1'b1; load = 1'b0;
        applyStimulus(10);

        // Random phase: mode switches, limit changes below count, loads and enable gaps.
        repeat (3000) begin
            rst_n = ($urandom_range(0, 199) != 0);
            en    = ($urandom_range(0, 9) < 8);
            load  = ($urandom_range(0, 24) == 0);
            load_val = WIDTH'($urandom());
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom());
            if ($urandom_range(0, 49) == 0) limit = WIDTH'($urandom_range(0, 20));
            if ($urandom_range(0, 59) == 0) prescale = PRE_W'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) cmp_val = WIDTH'($urandom_range(0, 20));
            applyStimulus(1);
        end

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        if (exp_q.size() > 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
